channel_dump_buffer: RTL and testbench

CHANNEL_DUMP_BUFFER -- requirements
Module: channel_dump_buffer

---
 rtl/channel_dump_buffer_pkg.sv | 30 +++
 rtl/channel_dump_buffer_dump_status_flags.sv | 51 +++++
 rtl/channel_dump_buffer.sv | 120 ++++++++++++
 tb/tb_channel_dump_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/channel_dump_buffer_pkg.sv
// ============================================================================
// channel_dump_buffer_pkg
// Shared register map, status bit positions and helpers for the dump buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package channel_dump_buffer_pkg;

    localparam logic [3:0] ADDR_I_EARLY  = 4'd0;
    localparam logic [3:0] ADDR_Q_EARLY  = 4'd1;
    localparam logic [3:0] ADDR_I_PROMPT = 4'd2;
    localparam logic [3:0] ADDR_Q_PROMPT = 4'd3;
    localparam logic [3:0] ADDR_I_LATE   = 4'd4;
    localparam logic [3:0] ADDR_Q_LATE   = 4'd5;
    localparam logic [3:0] ADDR_STATUS   = 4'd6;
    localparam logic [3:0] ADDR_CARRIER  = 4'd7;
    localparam logic [3:0] ADDR_CODE     = 4'd8;
    localparam logic [3:0] ADDR_EPOCH    = 4'd9;

    localparam int STATUS_NEW_DATA_BIT = 0;
    localparam int STATUS_OVERRUN_BIT  = 1;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/channel_dump_buffer_dump_status_flags.sv
// ============================================================================
// dump_status_flags
// new_data / overrun flag pair: set by dumps, cleared by a status read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dump_status_flags (
    input  logic clk,
    input  logic rstn,
    input  logic dump,
    input  logic status_read,
    output logic new_data,
    output logic overrun
);

    logic new_data_q, new_data_d;
    logic overrun_q,  overrun_d;

    // A dump landing on a status read counts as fresh data, not as an overrun.
    always_comb begin
        new_data_d = new_data_q;
        overrun_d  = overrun_q;
        if (status_read) begin
            new_data_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (dump) begin
            new_data_d = 1'b1;
            if (new_data_q && !status_read) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            new_data_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            new_data_q <= new_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign new_data = new_data_q;
    assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: rtl/channel_dump_buffer.sv
// ============================================================================
// channel_dump_buffer
// Captures correlator dumps and TIC snapshots; registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module channel_dump_buffer
    import channel_dump_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        dump,
    input  logic        tic_enable,
    input  logic [15:0] i_early,
    input  logic [15:0] q_early,
    input  logic [15:0] i_prompt,
    input  logic [15:0] q_prompt,
    input  logic [15:0] i_late,
    input  logic [15:0] q_late,
    input  logic [31:0] carrier_val,
    input  logic [20:0] code_val,
    input  logic [10:0] epoch,
    input  logic        rd_en,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        accum_int,
    output logic        overrun
);

    logic [15:0] i_early_q, q_early_q, i_prompt_q, q_prompt_q, i_late_q, q_late_q;
    logic [31:0] carrier_q;
    logic [20:0] code_q;
    logic [10:0] epoch_q;
    logic [31:0] rd_data_q, rd_data_d;
    logic        new_data;
    logic        status_read;
    logic [31:0] status_word;

    assign status_read = rd_en && (rd_addr == ADDR_STATUS);

    dump_status_flags u_flags (
        .clk         (clk),
        .rstn        (rstn),
        .dump        (dump),
        .status_read (status_read),
        .new_data    (new_data),
        .overrun     (overrun)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            i_early_q  <= '0;
            q_early_q  <= '0;
            i_prompt_q <= '0;
            q_prompt_q <= '0;
            i_late_q   <= '0;
            q_late_q   <= '0;
        end else if (dump) begin
            i_early_q  <= i_early;
            q_early_q  <= q_early;
            i_prompt_q <= i_prompt;
            q_prompt_q <= q_prompt;
            i_late_q   <= i_late;
            q_late_q   <= q_late;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            carrier_q <= '0;
            code_q    <= '0;
            epoch_q   <= '0;
        end else if (tic_enable) begin
            carrier_q <= carrier_val;
            code_q    <= code_val;
            epoch_q   <= epoch;
        end
    end

    always_comb begin
        status_word                      = '0;
        status_word[STATUS_NEW_DATA_BIT] = new_data;
        status_word[STATUS_OVERRUN_BIT]  = overrun;
    end

    // Mux reads the register outputs, so a same-edge capture is not yet visible.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            case (rd_addr)
                ADDR_I_EARLY:  rd_data_d = sext16(i_early_q);
                ADDR_Q_EARLY:  rd_data_d = sext16(q_early_q);
                ADDR_I_PROMPT: rd_data_d = sext16(i_prompt_q);
                ADDR_Q_PROMPT: rd_data_d = sext16(q_prompt_q);
                ADDR_I_LATE:   rd_data_d = sext16(i_late_q);
                ADDR_Q_LATE:   rd_data_d = sext16(q_late_q);
                ADDR_STATUS:   rd_data_d = status_word;
                ADDR_CARRIER:  rd_data_d = carrier_q;
                ADDR_CODE:     rd_data_d = {11'b0, code_q};
                ADDR_EPOCH:    rd_data_d = {21'b0, epoch_q};
                default:       rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign accum_int = new_data;

endmodule

`default_nettype wire

// File: tb/tb_channel_dump_buffer.sv
// ============================================================================
// tb_channel_dump_buffer
// Directed and randomized checks of channel_dump_buffer against a register-map model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_channel_dump_buffer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dump = 1'b0;
    logic        tic_enable = 1'b0;
    logic [15:0] i_early = '0, q_early = '0, i_prompt = '0, q_prompt = '0, i_late = '0, q_late = '0;
    logic [31:0] carrier_val = '0;
    logic [20:0] code_val = '0;
    logic [10:0] epoch = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        accum_int;
    logic        overrun;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    channel_dump_buffer dut (
        .clk         (clk),
        .rstn        (rstn),
        .dump        (dump),
        .tic_enable  (tic_enable),
        .i_early     (i_early),
        .q_early     (q_early),
        .i_prompt    (i_prompt),
        .q_prompt    (q_prompt),
        .i_late      (i_late),
        .q_late      (q_late),
        .carrier_val (carrier_val),
        .code_val    (code_val),
        .epoch       (epoch),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .accum_int   (accum_int),
        .overrun     (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Register-file model: a map of values plus two flags.
    logic [31:0] m_reg [16];
    logic        m_new = 1'b0;
    logic        m_ovr = 1'b0;
    logic [31:0] m_rd  = '0;

    initial for (int k = 0; k < 16; k++) m_reg[k] = '0;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 4'd6) return {30'b0, m_ovr, m_new};
        return m_reg[a];
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < 16; k++) m_reg[k] = '0;
            m_new = 1'b0;
            m_ovr = 1'b0;
            m_rd  = '0;
        end else begin
            logic had_new, sread;
            had_new = m_new;
            sread   = rd_en && rd_addr == 4'd6;
            if (rd_en) m_rd = m_read(rd_addr);
            if (sread) begin
                m_new = 1'b0;
                m_ovr = 1'b0;
            end
            if (dump) begin
                m_reg[0] = 32'($signed(i_early));
                m_reg[1] = 32'($signed(q_early));
                m_reg[2] = 32'($signed(i_prompt));
                m_reg[3] = 32'($signed(q_prompt));
                m_reg[4] = 32'($signed(i_late));
                m_reg[5] = 32'($signed(q_late));
                m_new = 1'b1;
                if (had_new && !sread) m_ovr = 1'b1;
            end
            if (tic_enable) begin
                m_reg[7] = carrier_val;
                m_reg[8] = 32'(code_val);
                m_reg[9] = 32'(epoch);
            end
        end
    end

    always @(negedge clk) begin
        check("rd_data_vs_model",   rd_data,          m_rd);
        check("accum_int_vs_model", {31'b0, accum_int}, {31'b0, m_new});
        check("overrun_vs_model",   {31'b0, overrun},   {31'b0, m_ovr});
    end

    // One clock cycle of stimulus, applied just after a falling edge.
    task automatic cyc(input logic d, input logic t, input logic r, input logic [3:0] a);
        dump = d; tic_enable = t; rd_en = r; rd_addr = a;
        @(negedge clk);
        dump = 1'b0; tic_enable = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 1, 1, 4'd6);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_accum_int", {31'b0, accum_int}, 32'h0);
        check("reset_overrun", {31'b0, overrun}, 32'h0);
        rstn = 1'b1;

        i_early = 16'h8001; q_late = 16'h7FFF; i_prompt = 16'h1234;
        cyc(1, 0, 0, 4'd0);
        cyc(0, 0, 1, 4'd0);
        check("read_i_early", rd_data, 32'hFFFF8001);
        cyc(0, 0, 1, 4'd5);
        check("read_q_late", rd_data, 32'h00007FFF);
        check("accum_int_set", {31'b0, accum_int}, 32'h1);

        cyc(0, 0, 1, 4'd6);
        check("status_first", rd_data, 32'h1);
        cyc(1, 0, 0, 4'd0);
        cyc(1, 0, 0, 4'd0);
        cyc(0, 0, 1, 4'd6);
        check("status_overrun", rd_data, 32'h3);
        cyc(0, 0, 1, 4'd6);
        check("status_cleared", rd_data, 32'h0);

        cyc(1, 0, 0, 4'd0);
        cyc(1, 0, 1, 4'd6);
        check("dump_on_status_rd", rd_data, 32'h1);
        check("dump_on_status_new", {31'b0, accum_int}, 32'h1);
        check("dump_on_status_ovr", {31'b0, overrun}, 32'h0);

        code_val = 21'h1FFFFF; epoch = 11'h7FF; carrier_val = 32'hDEADBEEF;
        cyc(0, 1, 0, 4'd0);
        cyc(0, 0, 1, 4'd7);
        check("tic_carrier", rd_data, 32'hDEADBEEF);
        cyc(0, 0, 1, 4'd8);
        check("tic_code", rd_data, 32'h001FFFFF);
        cyc(0, 0, 1, 4'd9);
        check("tic_epoch", rd_data, 32'h000007FF);
        cyc(0, 0, 1, 4'd12);
        check("unmapped_addr", rd_data, 32'h0);

        i_prompt = 16'h5678;
        cyc(1, 0, 1, 4'd2);
        check("read_vs_capture_old", rd_data, 32'h00001234);
        cyc(0, 0, 1, 4'd2);
        check("read_vs_capture_new", rd_data, 32'h00005678);

        rstn = 1'b0;
        cyc(1, 1, 1, 4'd2);
        rstn = 1'b1;
        check("rst_dump_rd_data", rd_data, 32'h0);
        check("rst_dump_accum", {31'b0, accum_int}, 32'h0);
        check("rst_dump_overrun", {31'b0, overrun}, 32'h0);
        cyc(1, 0, 0, 4'd0);
        check("post_rst_new", {31'b0, accum_int}, 32'h1);
        check("post_rst_ovr", {31'b0, overrun}, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            i_early  = 16'($urandom); q_early = 16'($urandom);
            i_prompt = 16'($urandom); q_prompt = 16'($urandom);
            i_late   = 16'($urandom); q_late = 16'($urandom);
            carrier_val = $urandom; code_val = 21'($urandom); epoch = 11'($urandom);
            rstn = ($urandom_range(0, 63) != 0);
            cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? 4'd6 : 4'($urandom));
        end
        rstn = 1'b1;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
